// File: rtl/tpu_seq_ctrl.sv
// Host-side job sequencer for the NxN systolic TPU core: operand staging RAMs,
// LOAD-A / LOAD-B / RUN / STORE instruction issue, and result capture for readback.
module tpu_seq_ctrl #(
    parameter int N          = 4,
    parameter int DATA_W     = 8,
    parameter int RES_W      = 8,
    parameter int RUN_CYCLES = 10,
    parameter int RES_LAT    = 1,
    localparam int ADDR_W    = (N > 1) ? $clog2(N) : 1,
    localparam int INSTR_W   = 4 + 2 * ADDR_W + DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [2*ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  start,
    input  logic                  reuse_b,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_err,
    output logic [INSTR_W-1:0]    instr,
    input  logic [RES_W-1:0]      result,
    input  logic [2*ADDR_W-1:0]   rd_addr,
    output logic [RES_W-1:0]      rd_data,
    output logic                  res_valid
);

    localparam int DEPTH   = 1 << (2 * ADDR_W);
    localparam int LAST    = N - 1;
    localparam int CNT_MAX = (RUN_CYCLES > RES_LAT) ? RUN_CYCLES : RES_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;
    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_STORE  = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    generate
        if (N < 2 || N > 8 || DATA_W < 1 || RES_W < 1 || RUN_CYCLES < 1 ||
            RES_LAT < 0 || RES_LAT > 4) begin : g_param_err
            $error("tpu_seq_ctrl: parameter value out of range");
        end
    endgenerate

    logic [DATA_W-1:0]              r_ram_a [DEPTH];
    logic [DATA_W-1:0]              r_ram_b [DEPTH];
    logic [RES_W-1:0]               r_cbuf  [DEPTH];

    state_t                         r_state;
    logic [ADDR_W-1:0]              r_row;
    logic [ADDR_W-1:0]              r_col;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_reuse;
    logic [RES_LAT:0]               r_pv;
    logic [RES_LAT:0][2*ADDR_W-1:0] r_pa;

    logic                           w_idle;
    logic                           w_wr_ok;
    logic [2*ADDR_W-1:0]            w_rc;
    logic                           w_last_rc;
    logic [ADDR_W-1:0]              w_row_nxt;
    logic [ADDR_W-1:0]              w_col_nxt;

    assign w_idle    = (r_state == S_IDLE);
    assign w_wr_ok   = wr_en & w_idle;
    assign w_rc      = {r_row, r_col};
    assign w_last_rc = (r_row == ADDR_W'(LAST)) && (r_col == ADDR_W'(LAST));

    // Row-major walk: column wraps at N-1 and carries into the row; the final step returns to 0,0.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (w_last_rc) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
        end else if (r_col == ADDR_W'(LAST)) begin
            w_row_nxt = r_row + ADDR_W'(1);
            w_col_nxt = '0;
        end else begin
            w_row_nxt = r_row;
            w_col_nxt = r_col + ADDR_W'(1);
        end
    end

    // Host writes into the operand staging RAMs (accepted only while idle).
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            if (wr_sel) begin
                r_ram_b[wr_addr] <= wr_data;
            end else begin
                r_ram_a[wr_addr] <= wr_data;
            end
        end
    end

    // Result capture: a STORE address leaves the pipe exactly when its result is on the bus.
    always_ff @(posedge clk) begin
        if (r_pv[RES_LAT]) begin
            r_cbuf[r_pa[RES_LAT]] <= result;
        end
    end

    // STORE address pipeline; stage 0 aligns with the STORE currently on instr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pa <= '0;
        end else begin
            r_pv[0] <= (r_state == S_STORE);
            r_pa[0] <= w_rc;
            for (int i = 1; i <= RES_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    // Registered readback port and rejected-write flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            wr_err  <= 1'b0;
        end else begin
            rd_data <= r_cbuf[rd_addr];
            wr_err  <= wr_en & ~w_idle;
        end
    end

    // Job sequencer with registered instruction and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_reuse   <= 1'b0;
            instr     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            done  <= 1'b0;
            instr <= {OP_NOP, {(INSTR_W-2){1'b0}}};
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_reuse   <= reuse_b;
                        res_valid <= 1'b0;
                        busy      <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    instr <= {OP_LOAD, SEL_A, r_row, r_col, r_ram_a[w_rc]};
                    r_row <= w_row_nxt;
                    r_col <= w_col_nxt;
                    if (w_last_rc) begin
                        r_state <= r_reuse ? S_RUN : S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    instr <= {OP_LOAD, SEL_B, r_row, r_col, r_ram_b[w_rc]};
                    r_row <= w_row_nxt;
                    r_col <= w_col_nxt;
                    if (w_last_rc) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    instr <= {OP_RUN, {(INSTR_W-2){1'b0}}};
                    if (r_cnt == CNT_W'(RUN_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STORE: begin
                    instr <= {OP_STORE, 2'b00, r_row, r_col, {DATA_W{1'b0}}};
                    r_row <= w_row_nxt;
                    r_col <= w_col_nxt;
                    if (w_last_rc) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(RES_LAT)) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        res_valid <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
